// File: rtl/pixel_controller.sv
// Global-shutter frame sequencer: ERASE -> EXPOSE -> CONVERT (count on DATA) -> TURN -> READ,
// then holds the read-back pixel value on a valid/ready port until the consumer takes it.
module pixel_controller #(
    parameter int ERASE_CYCLES  = 5,
    parameter int EXPOSE_CYCLES = 255,
    parameter int READ_CYCLES   = 5,
    parameter int DW            = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          erase,
    output logic          expose,
    output logic          convert,
    output logic          ramp_tick,
    output logic          read,
    output logic          data_oe,
    output logic [DW-1:0] data_out,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          busy
);

    localparam int CW = (DW + 1 > 16) ? DW + 1 : 16;

    localparam logic [CW-1:0] ERASE_LAST  = CW'(ERASE_CYCLES - 1);
    localparam logic [CW-1:0] EXPOSE_LAST = CW'(EXPOSE_CYCLES - 1);
    localparam logic [CW-1:0] CONV_LAST   = CW'((2 ** DW) - 1);
    localparam logic [CW-1:0] READ_LAST   = CW'(READ_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_TURN,
        S_READ,
        S_HOLD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Outputs are registered: each transition sets the levels for the first cycle of the new state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            erase     <= 1'b0;
            expose    <= 1'b0;
            convert   <= 1'b0;
            ramp_tick <= 1'b0;
            read      <= 1'b0;
            data_oe   <= 1'b0;
            data_out  <= '0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ERASE;
                        cnt   <= '0;
                        erase <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                S_ERASE: begin
                    if (cnt == ERASE_LAST) begin
                        state  <= S_EXPOSE;
                        cnt    <= '0;
                        erase  <= 1'b0;
                        expose <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_EXPOSE: begin
                    if (cnt == EXPOSE_LAST) begin
                        state     <= S_CONVERT;
                        cnt       <= '0;
                        expose    <= 1'b0;
                        convert   <= 1'b1;
                        ramp_tick <= 1'b1;
                        data_oe   <= 1'b1;
                        data_out  <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // data_out follows the phase counter so it reads n in conversion cycle n.
                S_CONVERT: begin
                    if (cnt == CONV_LAST) begin
                        state     <= S_TURN;
                        cnt       <= '0;
                        convert   <= 1'b0;
                        ramp_tick <= 1'b0;
                        data_oe   <= 1'b0;
                        data_out  <= '0;
                    end else begin
                        cnt      <= cnt + CW'(1);
                        data_out <= data_out + DW'(1);
                    end
                end

                // One dead cycle so the pixel never drives DATA while we still do.
                S_TURN: begin
                    state <= S_READ;
                    cnt   <= '0;
                    read  <= 1'b1;
                end

                S_READ: begin
                    if (cnt == READ_LAST) begin
                        state     <= S_HOLD;
                        cnt       <= '0;
                        read      <= 1'b0;
                        pix_data  <= data_in;
                        pix_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_HOLD: begin
                    if (pix_ready) begin
                        state     <= S_IDLE;
                        cnt       <= '0;
                        pix_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    cnt       <= '0;
                    erase     <= 1'b0;
                    expose    <= 1'b0;
                    convert   <= 1'b0;
                    ramp_tick <= 1'b0;
                    read      <= 1'b0;
                    data_oe   <= 1'b0;
                    data_out  <= '0;
                    pix_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_controller.sv
// Directed bench for pixel_controller: default-size instance with a tripping pixel model,
// plus a DW=4 / READ_CYCLES=2 instance with a pixel that never trips.
module tb_pixel_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance A: defaults
    logic       start_a, erase_a, expose_a, convert_a, ramp_tick_a, read_a, data_oe_a;
    logic [7:0] data_out_a, data_in_a, pix_data_a;
    logic       pix_valid_a, pix_ready_a, busy_a;

    // Instance B: DW=4, READ_CYCLES=2
    logic       start_b, erase_b, expose_b, convert_b, ramp_tick_b, read_b, data_oe_b;
    logic [3:0] data_out_b, data_in_b, pix_data_b;
    logic       pix_valid_b, pix_ready_b, busy_b;

    pixel_controller dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .erase(erase_a), .expose(expose_a), .convert(convert_a), .ramp_tick(ramp_tick_a),
        .read(read_a), .data_oe(data_oe_a), .data_out(data_out_a), .data_in(data_in_a),
        .pix_data(pix_data_a), .pix_valid(pix_valid_a), .pix_ready(pix_ready_a), .busy(busy_a)
    );

    pixel_controller #(.ERASE_CYCLES(5), .EXPOSE_CYCLES(255), .READ_CYCLES(2), .DW(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .erase(erase_b), .expose(expose_b), .convert(convert_b), .ramp_tick(ramp_tick_b),
        .read(read_b), .data_oe(data_oe_b), .data_out(data_out_b), .data_in(data_in_b),
        .pix_data(pix_data_b), .pix_valid(pix_valid_b), .pix_ready(pix_ready_b), .busy(busy_b)
    );

    // Pixel model A: latches the first count at or above trip_a; stays 0xFF if it never trips.
    int         trip_a = 1000;
    logic [7:0] latch_a;
    logic       tripped_a;
    always @(posedge clk) begin
        if (erase_a) begin
            latch_a   <= 8'hFF;
            tripped_a <= 1'b0;
        end else if (data_oe_a && !tripped_a && (int'(data_out_a) >= trip_a)) begin
            latch_a   <= data_out_a;
            tripped_a <= 1'b1;
        end
    end
    assign data_in_a = read_a ? latch_a : 8'h00;
    assign data_in_b = read_b ? 4'hF : 4'h0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor on instance A, sampled on the falling edge
    int         ramp_cnt = 0, dout_err = 0, contention = 0, turn_cnt = 0, vcyc = 0, vrise = 0;
    logic [7:0] exp_idx = 8'h00;
    logic       vprev = 1'b0;
    always @(negedge clk) begin
        if (ramp_tick_a === 1'b1) begin
            ramp_cnt++;
            if (data_out_a !== exp_idx) dout_err++;
            exp_idx = exp_idx + 8'd1;
        end else begin
            exp_idx = 8'h00;
        end
        if (data_oe_a && read_a) contention++;
        if (busy_a && !erase_a && !expose_a && !convert_a && !data_oe_a && !read_a && !pix_valid_a)
            turn_cnt++;
        if (pix_valid_a === 1'b1) vcyc++;
        if (pix_valid_a === 1'b1 && vprev == 1'b0) vrise++;
        vprev = (pix_valid_a === 1'b1);
    end

    task automatic frame_a(input int trip, input bit inj, input int stall, input logic [7:0] exp_data);
        int n, r0, t0, v0, c0;
        bit held, idle_ok;
        trip_a = trip;
        r0 = ramp_cnt; t0 = turn_cnt; v0 = vrise; c0 = vcyc;
        pix_ready_a = (stall == 0);
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        chk("busy_rise", 32'(busy_a), 32'd1);
        chk("erase_on", 32'(erase_a), 32'd1);
        n = 0;
        while (!pix_valid_a && n < 2000) begin
            start_a = inj && (n == 100);
            @(negedge clk);
            n++;
        end
        start_a = 1'b0;
        chk("latency", 32'(n), 32'd522);
        chk("pix_data", 32'(pix_data_a), 32'(exp_data));
        held = 1'b1;
        for (int i = 0; i < stall; i++) begin
            start_a = inj && (i == 3);
            @(negedge clk);
            if (pix_valid_a !== 1'b1 || pix_data_a !== exp_data) held = 1'b0;
        end
        start_a = 1'b0;
        pix_ready_a = 1'b1;
        if (stall > 0) chk("hold_stable", 32'(held), 32'd1);
        @(negedge clk);
        chk("valid_drop", 32'(pix_valid_a), 32'd0);
        chk("busy_fall", 32'(busy_a), 32'd0);
        chk("data_keep", 32'(pix_data_a), 32'(exp_data));
        idle_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (busy_a !== 1'b0) idle_ok = 1'b0;
        end
        #1;
        chk("no_queue", 32'(idle_ok), 32'd1);
        chk("ramps", ramp_cnt - r0, 256);
        chk("turn_one", turn_cnt - t0, 1);
        chk("vrise_one", vrise - v0, 1);
        chk("vcycles", vcyc - c0, stall + 1);
    endtask

    initial begin
        int n, v0, rb;
        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        pix_ready_a = 1'b1; pix_ready_b = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_a", 32'({erase_a, expose_a, convert_a, ramp_tick_a, read_a, data_oe_a,
                          pix_valid_a, busy_a, data_out_a, pix_data_a}), 32'd0);
        chk("rst_b", 32'({erase_b, expose_b, convert_b, ramp_tick_b, read_b, data_oe_b,
                          pix_valid_b, busy_b, data_out_b, pix_data_b}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy_a), 32'd0);

        // Basic, backpressure, start-while-busy frames back to back
        frame_a(8'h80, 1'b0, 0, 8'h80);
        frame_a(8'h33, 1'b0, 10, 8'h33);
        frame_a(8'h10, 1'b1, 4, 8'h10);

        // Reset in the middle of conversion
        trip_a = 8'h80;
        v0 = vrise;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        n = 0;
        while (!(convert_a && data_out_a == 8'h40) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_40", 32'(data_out_a), 32'h40);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid", 32'({erase_a, expose_a, convert_a, ramp_tick_a, read_a, data_oe_a,
                            pix_valid_a, busy_a, data_out_a, pix_data_a}), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_idle", 32'(busy_a), 32'd0);
        chk("rst_no_valid", vrise - v0, 0);

        frame_a(8'h80, 1'b0, 0, 8'h80);
        frame_a(1000, 1'b0, 0, 8'hFF);

        chk("dout_steps", dout_err, 0);
        chk("contention", contention, 0);

        // Never-trip pixel on the narrow instance
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        n = 0; rb = 0;
        while (!pix_valid_b && n < 2000) begin
            @(negedge clk);
            n++;
            if (ramp_tick_b) rb++;
        end
        chk("lat_b", 32'(n), 32'd279);
        chk("pix_b", 32'(pix_data_b), 32'hF);
        chk("ramps_b", rb, 16);
        @(negedge clk);
        chk("busy_b", 32'(busy_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_controller.md
# pixel_controller

Global-shutter frame sequencer for the digital pixel sensor. It drives the pixel's ERASE/EXPOSE/READ controls and generates the conversion ramp strobe. It drives the 8-bit Gray-free binary count onto the shared pixel data bus during conversion, so the pixel latches the count at which its comparator trips. It then turns the bus around, reads the latched value back, and presents it on a valid/ready output port.

## Interface
- ERASE_CYCLES, 5: cycles ERASE is held high.
- EXPOSE_CYCLES, 255: cycles EXPOSE is held high (1..65535).
- READ_CYCLES, 5: cycles READ is held high (>=2).
- DW, 8: data bus / counter width.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run a frame; honoured only in IDLE.
- erase  out  1  to pixel ERASE.
- expose  out  1  to pixel EXPOSE.
- convert  out  1  high for the whole conversion window; gates BIAS/ramp analog clocks.
- ramp_tick  out  1  one pulse per conversion count; drives pixel RAMP_CLK.
- read  out  1  to pixel READ.
- data_oe  out  1  controller drives DATA when high (external tristate).
- data_out  out  DW  count value driven onto DATA.
- data_in  in  DW  DATA as seen by the controller (pixel-driven during READ).
- pix_data  out  DW  captured pixel value.
- pix_valid  out  1  pix_data valid.
- pix_ready  in  1  consumer accepts pix_data.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ERASE, EXPOSE, CONVERT, TURN, READ, HOLD.
- IDLE: all outputs low/zero. start=1 -> ERASE.
- ERASE: erase=1 for ERASE_CYCLES cycles -> EXPOSE.
- EXPOSE: expose=1 for EXPOSE_CYCLES cycles -> CONVERT.
- CONVERT: 2^DW cycles. Counter runs 0..2^DW-1, one step per cycle. data_out=counter, data_oe=1, convert=1, ramp_tick=1 every cycle. At count 2^DW-1 -> TURN.
- TURN: one cycle with data_oe=0 and read=0 (bus turnaround, no contention) -> READ.
- READ: read=1 for READ_CYCLES cycles. data_in is sampled into pix_data on the last READ cycle -> HOLD.
- HOLD: pix_valid=1, pix_data stable. Transfer on pix_valid&&pix_ready at a clock edge -> IDLE; pix_valid is low the next cycle.
- start outside IDLE is ignored and never queued.
- data_oe and read are never both high in the same cycle.
- The phase counter is reused across states and cleared on every state change. Counter width is max(16, DW+1) bits with no wrap inside a state.
- pix_data holds its last value after the handshake until the next capture.

## Timing
- All outputs are registered. Reset value is 0 for every output, including pix_data. FSM resets to IDLE.
- Reset asserted mid-frame: all outputs drop asynchronously, FSM returns to IDLE, and no partial pix_valid is produced. The pixel's stored value is don't-care.
- start sampled high in IDLE at edge k: erase=1 from cycle k+1.
- Frame latency from the start edge to pix_valid=1 is ERASE_CYCLES+EXPOSE_CYCLES+2^DW+1+READ_CYCLES cycles. Defaults give 5+255+256+1+5 = 522.
- In CONVERT cycle n (n=0..2^DW-1), data_out=n.
- If pix_ready is already high when pix_valid rises, the transfer happens on that edge and pix_valid lasts exactly 1 cycle.
- busy rises the cycle after start and falls the cycle after the transfer.

## Test plan
- Basic frame: defaults, pixel model trips at count 0x80, pix_ready=1. Expect one pix_valid pulse with pix_data=0x80 at 522 cycles after start, 256 ramp_tick pulses, and data_out stepping 0x00..0xFF.
- Backpressure: pix_ready=0 for 10 cycles after pix_valid rises. Expect pix_valid and pix_data held constant for 10 cycles, then the transfer, then IDLE/busy=0 one cycle later.
- Start while busy: pulse start during EXPOSE and again during HOLD. Expect no extra frame, frame length unchanged, and exactly one pix_valid.
- Reset mid-CONVERT: assert reset at count 0x40. Expect all outputs 0 immediately and state IDLE. A new start produces a full frame with data_out restarting at 0x00.
- Bus contention check: across 3 back-to-back frames, assert data_oe&&read never true. Expect exactly one TURN cycle with both low between the last ramp_tick and the first read.
- Never-trip pixel: pixel model that never trips returns 0xFF. Expect pix_data=0xFF; with DW=4 and READ_CYCLES=2, expect latency 5+255+16+1+2=279 cycles.
